uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised successor to the team's fixed 8N1 UART receiver.
- Configurable clock/baud ratio, data width, parity mode and stop-bit count.
- Adds an input synchroniser, false-start rejection, parity/framing error reporting and break handling.
- Sits between the board RX pin and the command/display logic; delivers one word per frame with a single-cycle valid strobe.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD (integer divide), HALF = BAUD_DIV/2; BAUD_DIV >= 4 required
DATA_BITS, 8, data bits per frame, legal 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, legal 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (rst==0 resets immediately)
din  input  1  asynchronous serial line, idle high
valid  output  1  one-cycle strobe: data/parity_err/frame_err valid this cycle
data  output  DATA_BITS  received word, LSB first on the line
parity_err  output  1  parity mismatch on the frame in this valid cycle (0 when PARITY=0)
frame_err  output  1  a sampled stop bit was low in this valid cycle
busy  output  1  high from start detection until return to IDLE

Behaviour:
- Reset values: valid=0, data=0, parity_err=0, frame_err=0, busy=0; FSM=IDLE; counters=0; armed=1.
- rst low mid-frame aborts the frame immediately; no valid is produced for that frame.
- din passes through a 2-FF synchroniser (reset value 1); all logic uses the synchronised value ds.
- Bit counter counts 0..BAUD_DIV-1; the width is derived from BAUD_DIV.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - When armed=1 and ds==0, move to START on the next cycle (t0 = first cycle ds==0), clear the counter, and set busy=1.
  - If armed=0, wait for ds==1, then set armed=1.
- START:
  - Sample ds at t0+HALF.
  - If ds==1, it is a false start: return to IDLE, busy=0, no valid.
  - Else go to DATA.
- Sample timing: bit n (start=0, data 1..DATA_BITS, then parity if enabled, then stop bits) is sampled at t0+HALF+n*BAUD_DIV, i.e. at mid-bit.
- DATA: shift the sample into the word LSB first; after DATA_BITS samples go to PARITY if PARITY!=0, else STOP.
- PARITY:
  - The sample plus XOR of data bits must equal 1 for odd and 0 for even.
  - A mismatch latches perr.
- STOP:
  - Sample STOP_BITS stop bits; any low sample latches ferr.
  - After the last stop sample, on the next cycle:
    - valid=1 for exactly one cycle;
    - data = word;
    - parity_err = perr;
    - frame_err = ferr.
  - FSM returns to IDLE in that same cycle, busy=0, and the internal perr/ferr are cleared.
- data holds its value until the next valid. parity_err and frame_err are 0 whenever valid=0.
- Frames carrying errors are still delivered (valid=1 with flags set).
- Back-to-back frames: returning to IDLE at mid-stop allows a start edge as early as the stop bit's end; no frame is lost at full line rate.
- Break:
  - A frame whose data bits and stop bit(s) all sample 0 is delivered with frame_err=1 and data=0.
  - armed is then cleared, so no new start is accepted until ds has been seen high.
  - This prevents repeated phantom frames during a held-low line.
- Any unreachable state encoding recovers to IDLE.

Test Plan:
- Use CLK_FREQ=16, BAUD=1 (BAUD_DIV=16, HALF=8) unless noted.
- 8N1, send 0xA5 -> exactly one valid pulse 1 cycle after the stop sample; data=0xA5, parity_err=0, frame_err=0, busy low the same cycle.
- DATA_BITS=7, PARITY=2 (even), send 0x35 with the correct parity bit 0 -> data=0x35, parity_err=0. Flip the parity bit -> data=0x35, parity_err=1.
- Glitch din low for 4 cycles (< HALF) -> no valid, busy returns to 0, the next proper frame 0x3C is received correctly.
- STOP_BITS=2, second stop bit driven low -> valid with frame_err=1. Follow it with 8N1-style frames 0x00, 0xFF, 0x81 back-to-back with no idle gap -> three valids in order, each data correct, no errors.
- Hold din low for 30 bit times -> exactly one valid (data=0x00, frame_err=1), no further valid until din returns high, then frame 0x5A is received correctly.
- Assert rst low mid-DATA of frame 0x77 -> all outputs 0 immediately, no valid for that frame. After release, frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx_param_if.sv
// rtl/uart_rx_param_if.sv - serial line in and received-word strobe out for uart_rx_param
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 din;
    logic                 valid;
    logic [DATA_BITS-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  din,
        output valid, data, parity_err, frame_err, busy
    );

    modport slave (
        output din,
        input  valid, data, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with input sync, false-start rejection,
// parity/framing error flags and break lockout
module uart_rx_param #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_param_if.master bus
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int HALF     = BAUD_DIV / 2;
    localparam int CW       = $clog2(BAUD_DIV);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t               state, state_next;
    logic                 sync1, ds;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] word;
    logic                 perr, ferr, stop_low, armed;
    logic                 valid_r, perr_r, ferr_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 tick, last_data, last_stop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            ds    <= 1'b1;
        end else begin
            sync1 <= bus.din;
            ds    <= sync1;
        end
    end

    // The start bit is sampled half a bit in; every later sample is a full bit apart.
    assign tick      = (state == S_START) ? (cnt == CW'(HALF - 1)) : (cnt == CW'(BAUD_DIV - 1));
    assign last_data = (bit_idx == 4'(DATA_BITS - 1));
    assign last_stop = (bit_idx == 4'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (armed && !ds) state_next = S_START;
            S_START: if (tick) state_next = ds ? S_IDLE : S_DATA;
            S_DATA:  if (tick && last_data) state_next = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (tick) state_next = S_STOP;
            S_STOP:  if (tick && last_stop) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            bit_idx  <= '0;
            word     <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            stop_low <= 1'b1;
            armed    <= 1'b1;
            valid_r  <= 1'b0;
            data_r   <= '0;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            if (state == S_IDLE || state_next == S_IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= tick ? '0 : cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    bit_idx  <= '0;
                    perr     <= 1'b0;
                    ferr     <= 1'b0;
                    stop_low <= 1'b1;
                    if (!armed && ds) armed <= 1'b1;
                end
                S_DATA: if (tick) begin
                    word    <= {ds, word[DATA_BITS-1:1]};
                    bit_idx <= last_data ? 4'd0 : bit_idx + 4'd1;
                end
                S_PAR: if (tick) begin
                    if ((ds ^ (^word)) != (PARITY == 1)) perr <= 1'b1;
                end
                S_STOP: if (tick) begin
                    if (!ds) ferr <= 1'b1;
                    else     stop_low <= 1'b0;
                    if (last_stop) begin
                        valid_r <= 1'b1;
                        data_r  <= word;
                        perr_r  <= perr;
                        ferr_r  <= ferr | ~ds;
                        // A held-low line must be seen high again before the next start.
                        if (word == '0 && stop_low && !ds) armed <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.valid      = valid_r;
    assign bus.data       = data_r;
    assign bus.parity_err = perr_r;
    assign bus.frame_err  = ferr_r;
    assign bus.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed bench for uart_rx_param in 8N1, 7E1 and 8N2 builds
module tb_uart_rx_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start = 0;

    uart_rx_param_if #(.DATA_BITS(8)) i1 ();
    uart_rx_param_if #(.DATA_BITS(7)) i2 ();
    uart_rx_param_if #(.DATA_BITS(8)) i3 ();

    uart_rx_param #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        d1 (.clk(clk), .rst(rst), .bus(i1));
    uart_rx_param #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1))
        d2 (.clk(clk), .rst(rst), .bus(i2));
    uart_rx_param #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
        d3 (.clk(clk), .rst(rst), .bus(i3));

    int n1 = 0, n2 = 0, n3 = 0, viol = 0, cyc1 = 0;
    logic [7:0] q1[$];
    logic [6:0] dat2 = '0;
    logic [7:0] dat3 = '0;
    logic pe1 = 0, fe1 = 0, bz1 = 0, pe2 = 0, fe2 = 0, pe3 = 0, fe3 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (i1.valid) begin
            n1++; q1.push_back(i1.data); pe1 = i1.parity_err; fe1 = i1.frame_err;
            bz1 = i1.busy; cyc1 = cyc;
        end
        if (i2.valid) begin n2++; dat2 = i2.data; pe2 = i2.parity_err; fe2 = i2.frame_err; end
        if (i3.valid) begin n3++; dat3 = i3.data; pe3 = i3.parity_err; fe3 = i3.frame_err; end
        if (!i1.valid && (i1.parity_err || i1.frame_err)) viol++;
        if (!i2.valid && (i2.parity_err || i2.frame_err)) viol++;
        if (!i3.valid && (i3.parity_err || i3.frame_err)) viol++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_din(input int w, input logic v);
        case (w)
            1:       i1.din = v;
            2:       i2.din = v;
            default: i3.din = v;
        endcase
    endtask

    task automatic send_frame(input int w, input int nbits, input logic [7:0] d,
                              input int par, input int nstop, input logic [1:0] stops);
        last_start = cyc;
        set_din(w, 1'b0);
        wait_cyc(16);
        for (int i = 0; i < nbits; i++) begin set_din(w, d[i]); wait_cyc(16); end
        if (par >= 0) begin set_din(w, par[0]); wait_cyc(16); end
        for (int i = 0; i < nstop; i++) begin set_din(w, stops[i]); wait_cyc(16); end
        set_din(w, 1'b1);
    endtask

    task automatic test_reset;
        wait_cyc(3);
        checks++; if (i1.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", i1.valid); end
        checks++; if (i1.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", i1.data); end
        checks++; if (i1.parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", i1.parity_err); end
        checks++; if (i1.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", i1.frame_err); end
        checks++; if (i1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", i1.busy); end
        rst = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_basic_8n1;
        int n;
        n = n1;
        send_frame(1, 8, 8'hA5, -1, 1, 2'b11);
        wait_cyc(16);
        checks++; if (n1 - n !== 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", n1 - n); end
        checks++; if (q1[$] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", q1[$]); end
        checks++; if (pe1 !== 1'b0 || fe1 !== 1'b0) begin errors++; $display("FAIL basic_flags: got pe=%b fe=%b expected 0 0", pe1, fe1); end
        checks++; if (bz1 !== 1'b0) begin errors++; $display("FAIL basic_busy_at_valid: got %b expected 0", bz1); end
        checks++; if (cyc1 - last_start !== 155) begin errors++; $display("FAIL basic_latency: got %0d expected 155", cyc1 - last_start); end
    endtask

    task automatic test_parity;
        int n;
        n = n2;
        send_frame(2, 7, 8'h35, 0, 1, 2'b11);
        wait_cyc(16);
        checks++; if (n2 - n !== 1) begin errors++; $display("FAIL par_ok_count: got %0d expected 1", n2 - n); end
        checks++; if (dat2 !== 7'h35) begin errors++; $display("FAIL par_ok_data: got %h expected 35", dat2); end
        checks++; if (pe2 !== 1'b0 || fe2 !== 1'b0) begin errors++; $display("FAIL par_ok_flags: got pe=%b fe=%b expected 0 0", pe2, fe2); end
        send_frame(2, 7, 8'h35, 1, 1, 2'b11);
        wait_cyc(16);
        checks++; if (n2 - n !== 2) begin errors++; $display("FAIL par_bad_count: got %0d expected 2", n2 - n); end
        checks++; if (dat2 !== 7'h35) begin errors++; $display("FAIL par_bad_data: got %h expected 35", dat2); end
        checks++; if (pe2 !== 1'b1 || fe2 !== 1'b0) begin errors++; $display("FAIL par_bad_flags: got pe=%b fe=%b expected 1 0", pe2, fe2); end
    endtask

    task automatic test_glitch;
        int n;
        n = n1;
        set_din(1, 1'b0);
        wait_cyc(4);
        set_din(1, 1'b1);
        wait_cyc(40);
        checks++; if (n1 !== n) begin errors++; $display("FAIL glitch_no_valid: got %0d expected %0d", n1, n); end
        checks++; if (i1.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", i1.busy); end
        send_frame(1, 8, 8'h3C, -1, 1, 2'b11);
        wait_cyc(16);
        checks++; if (n1 - n !== 1) begin errors++; $display("FAIL glitch_next_count: got %0d expected 1", n1 - n); end
        checks++; if (q1[$] !== 8'h3C || fe1 !== 1'b0) begin errors++; $display("FAIL glitch_next_data: got %h fe=%b expected 3c fe=0", q1[$], fe1); end
    endtask

    task automatic test_two_stop;
        int n;
        n = n3;
        send_frame(3, 8, 8'hC3, -1, 2, 2'b01);
        wait_cyc(16);
        checks++; if (n3 - n !== 1) begin errors++; $display("FAIL stop2_count: got %0d expected 1", n3 - n); end
        checks++; if (dat3 !== 8'hC3) begin errors++; $display("FAIL stop2_data: got %h expected c3", dat3); end
        checks++; if (fe3 !== 1'b1 || pe3 !== 1'b0) begin errors++; $display("FAIL stop2_flags: got fe=%b pe=%b expected 1 0", fe3, pe3); end
    endtask

    task automatic test_back_to_back;
        int n;
        n = n1;
        send_frame(1, 8, 8'h00, -1, 1, 2'b11);
        send_frame(1, 8, 8'hFF, -1, 1, 2'b11);
        send_frame(1, 8, 8'h81, -1, 1, 2'b11);
        wait_cyc(16);
        checks++; if (n1 - n !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", n1 - n); end
        if (n1 - n >= 3) begin
            checks++; if (q1[$-2] !== 8'h00) begin errors++; $display("FAIL b2b_data0: got %h expected 00", q1[$-2]); end
            checks++; if (q1[$-1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1: got %h expected ff", q1[$-1]); end
            checks++; if (q1[$] !== 8'h81) begin errors++; $display("FAIL b2b_data2: got %h expected 81", q1[$]); end
        end
        checks++; if (fe1 !== 1'b0 || pe1 !== 1'b0) begin errors++; $display("FAIL b2b_flags: got fe=%b pe=%b expected 0 0", fe1, pe1); end
    endtask

    task automatic test_break;
        int n;
        n = n1;
        set_din(1, 1'b0);
        wait_cyc(480);
        checks++; if (n1 - n !== 1) begin errors++; $display("FAIL break_count: got %0d expected 1", n1 - n); end
        checks++; if (q1[$] !== 8'h00 || fe1 !== 1'b1) begin errors++; $display("FAIL break_frame: got %h fe=%b expected 00 fe=1", q1[$], fe1); end
        checks++; if (i1.busy !== 1'b0) begin errors++; $display("FAIL break_busy: got %b expected 0", i1.busy); end
        set_din(1, 1'b1);
        wait_cyc(32);
        checks++; if (n1 - n !== 1) begin errors++; $display("FAIL break_release_count: got %0d expected 1", n1 - n); end
        send_frame(1, 8, 8'h5A, -1, 1, 2'b11);
        wait_cyc(16);
        checks++; if (n1 - n !== 2) begin errors++; $display("FAIL break_next_count: got %0d expected 2", n1 - n); end
        checks++; if (q1[$] !== 8'h5A || fe1 !== 1'b0) begin errors++; $display("FAIL break_next_data: got %h fe=%b expected 5a fe=0", q1[$], fe1); end
    endtask

    task automatic test_reset_mid;
        int n;
        logic [7:0] d;
        n = n1;
        d = 8'h77;
        set_din(1, 1'b0);
        wait_cyc(16);
        for (int i = 0; i < 3; i++) begin set_din(1, d[i]); wait_cyc(16); end
        wait_cyc(8);
        rst = 1'b0;
        #2;
        checks++; if (i1.busy !== 1'b0 || i1.valid !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got busy=%b valid=%b expected 0 0", i1.busy, i1.valid); end
        checks++; if (i1.data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", i1.data); end
        checks++; if (i1.parity_err !== 1'b0 || i1.frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got pe=%b fe=%b expected 0 0", i1.parity_err, i1.frame_err); end
        set_din(1, 1'b1);
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(160);
        checks++; if (n1 !== n) begin errors++; $display("FAIL rstmid_no_valid: got %0d expected %0d", n1, n); end
        send_frame(1, 8, 8'h12, -1, 1, 2'b11);
        wait_cyc(16);
        checks++; if (n1 - n !== 1) begin errors++; $display("FAIL rstmid_next_count: got %0d expected 1", n1 - n); end
        checks++; if (q1[$] !== 8'h12 || fe1 !== 1'b0) begin errors++; $display("FAIL rstmid_next_data: got %h fe=%b expected 12 fe=0", q1[$], fe1); end
    endtask

    task automatic test_flags_idle;
        checks++; if (viol !== 0) begin errors++; $display("FAIL flags_without_valid: got %0d cycles expected 0", viol); end
    endtask

    initial begin
        i1.din = 1'b1;
        i2.din = 1'b1;
        i3.din = 1'b1;
        test_reset();
        test_basic_8n1();
        test_parity();
        test_glitch();
        test_two_stop();
        test_back_to_back();
        test_break();
        test_reset_mid();
        test_flags_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
